// File: rtl/fw_pkg.sv
// Shared types and constants for the result-forwarding pipe.
// Unit indices, completion-stage latencies, and the per-stage entry layout.
package fw_pkg;

    localparam int FW_DATA_WD     = 128;
    localparam int FW_ADDR_WD     = 7;
    localparam int FW_IDX_WD      = 3;
    localparam int FW_NUM_UNITS   = 8;
    localparam int NUM_RES_STAGES = 8;

    localparam logic [FW_IDX_WD-1:0] UNIT_NONE = 3'd0;
    localparam logic [FW_IDX_WD-1:0] UNIT_FX1  = 3'd1;
    localparam logic [FW_IDX_WD-1:0] UNIT_FX2  = 3'd2;
    localparam logic [FW_IDX_WD-1:0] UNIT_FPU  = 3'd3;
    localparam logic [FW_IDX_WD-1:0] UNIT_BYTE = 3'd4;
    localparam logic [FW_IDX_WD-1:0] UNIT_SHUF = 3'd5;
    localparam logic [FW_IDX_WD-1:0] UNIT_LS   = 3'd6;
    localparam logic [FW_IDX_WD-1:0] UNIT_BR   = 3'd7;

    // Completion stage per unit; 0 means the unit never produces a result.
    function automatic int unit_lat(input logic [FW_IDX_WD-1:0] idx);
        int lat;
        case (idx)
            UNIT_FX1:  lat = 2;
            UNIT_FX2:  lat = 3;
            UNIT_BYTE: lat = 3;
            UNIT_SHUF: lat = 4;
            UNIT_FPU:  lat = 6;
            UNIT_LS:   lat = 6;
            default:   lat = 0;
        endcase
        return lat;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [FW_ADDR_WD-1:0] addr;
        logic [FW_IDX_WD-1:0]  idx;
        logic [FW_DATA_WD-1:0] data;
    } res_entry_t;

endpackage

// File: rtl/fw_res_stage.sv
// One result stage: registers the entry from the previous stage, loading
// the owning unit's result when this stage is that unit's completion stage.
module fw_res_stage
    import fw_pkg::*;
#(
    parameter int STAGE      = 1,
    parameter bit FLUSH_KILL = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  res_entry_t                         stage_in,
    input  logic [FW_NUM_UNITS*FW_DATA_WD-1:0] unit_res,
    output res_entry_t                         stage_q
);

    res_entry_t nxt;
    logic       capture;

    // Flush is applied last so a killed entry never carries captured data.
    always_comb begin
        capture = stage_in.valid && (unit_lat(stage_in.idx) == STAGE);
        nxt     = stage_in;
        if (capture) begin
            nxt.data = unit_res[int'(stage_in.idx)*FW_DATA_WD +: FW_DATA_WD];
        end
        if (FLUSH_KILL && flush) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= nxt;
        end
    end

endmodule

// File: rtl/fw_result_pipe.sv
// Producer side of the operand-forwarding network: carries issued tags through
// s1..s8, captures unit results at their completion stage, and writes back from s8.
module fw_result_pipe
    import fw_pkg::*;
#(
    parameter int REG_DATA_WD  = FW_DATA_WD,
    parameter int ADDR_WD      = FW_ADDR_WD,
    parameter int NUM_UNITS    = FW_NUM_UNITS,
    parameter int FLUSH_STAGES = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    input  logic [ADDR_WD-1:0]               issue_rt_addr,
    input  logic [2:0]                       issue_idx,
    input  logic                             issue_wr_en,
    input  logic [NUM_UNITS*REG_DATA_WD-1:0] unit_res,
    input  logic                             flush,
    output logic [ADDR_WD-1:0]               rf_addr_s2,
    output logic [ADDR_WD-1:0]               rf_addr_s3,
    output logic [ADDR_WD-1:0]               rf_addr_s4,
    output logic [ADDR_WD-1:0]               rf_addr_s5,
    output logic [ADDR_WD-1:0]               rf_addr_s6,
    output logic [ADDR_WD-1:0]               rf_addr_s7,
    output logic [REG_DATA_WD-1:0]           rf_data_s2,
    output logic [REG_DATA_WD-1:0]           rf_data_s3,
    output logic [REG_DATA_WD-1:0]           rf_data_s4,
    output logic [REG_DATA_WD-1:0]           rf_data_s5,
    output logic [REG_DATA_WD-1:0]           rf_data_s6,
    output logic [REG_DATA_WD-1:0]           rf_data_s7,
    output logic [2:0]                       rf_idx_s2,
    output logic [2:0]                       rf_idx_s3,
    output logic [2:0]                       rf_idx_s4,
    output logic [2:0]                       rf_idx_s5,
    output logic [2:0]                       rf_idx_s6,
    output logic [2:0]                       rf_idx_s7,
    output logic [ADDR_WD-1:0]               rf_addr,
    output logic [REG_DATA_WD-1:0]           rf_data,
    output logic                             rf_we,
    output logic                             busy
);

    res_entry_t issue_entry;
    res_entry_t stg [1:NUM_RES_STAGES];

    // Non-writing instructions and resultless units enter as bubbles.
    always_comb begin
        issue_entry = '0;
        if (issue_valid && issue_wr_en &&
            (issue_idx != UNIT_NONE) && (issue_idx != UNIT_BR)) begin
            issue_entry.valid = 1'b1;
            issue_entry.addr  = issue_rt_addr;
            issue_entry.idx   = issue_idx;
        end
    end

    for (genvar k = 1; k <= NUM_RES_STAGES; k++) begin : g_stage
        res_entry_t stage_in;

        if (k == 1) begin : g_head
            assign stage_in = issue_entry;
        end else begin : g_body
            assign stage_in = stg[k-1];
        end

        // Stages s1..FLUSH_STAGES+1 load bubbles on flush, killing s1..FLUSH_STAGES.
        fw_res_stage #(
            .STAGE      (k),
            .FLUSH_KILL (k <= FLUSH_STAGES + 1)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .stage_in (stage_in),
            .unit_res (unit_res),
            .stage_q  (stg[k])
        );
    end

    assign rf_addr_s2 = stg[2].addr;
    assign rf_addr_s3 = stg[3].addr;
    assign rf_addr_s4 = stg[4].addr;
    assign rf_addr_s5 = stg[5].addr;
    assign rf_addr_s6 = stg[6].addr;
    assign rf_addr_s7 = stg[7].addr;

    assign rf_data_s2 = stg[2].data;
    assign rf_data_s3 = stg[3].data;
    assign rf_data_s4 = stg[4].data;
    assign rf_data_s5 = stg[5].data;
    assign rf_data_s6 = stg[6].data;
    assign rf_data_s7 = stg[7].data;

    assign rf_idx_s2  = stg[2].idx;
    assign rf_idx_s3  = stg[3].idx;
    assign rf_idx_s4  = stg[4].idx;
    assign rf_idx_s5  = stg[5].idx;
    assign rf_idx_s6  = stg[6].idx;
    assign rf_idx_s7  = stg[7].idx;

    assign rf_addr = stg[NUM_RES_STAGES].addr;
    assign rf_data = stg[NUM_RES_STAGES].data;
    assign rf_we   = stg[NUM_RES_STAGES].valid;

    always_comb begin
        busy = 1'b0;
        for (int i = 1; i <= NUM_RES_STAGES; i++) begin
            busy = busy | stg[i].valid;
        end
    end

endmodule

// File: tb/tb_fw_result_pipe.sv
// Directed self-checking bench for fw_result_pipe: capture stages, writeback
// ordering, flush kill window, bubble filtering and mid-flight reset.
module tb_fw_result_pipe;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [6:0]    issue_rt_addr;
    logic [2:0]    issue_idx;
    logic          issue_wr_en;
    logic [1023:0] unit_res;
    logic          flush;
    logic [6:0]    rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7;
    logic [127:0]  rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7;
    logic [2:0]    rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7;
    logic [6:0]    rf_addr;
    logic [127:0]  rf_data;
    logic          rf_we;
    logic          busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DATA_A5   = {16{8'hA5}};
    localparam logic [127:0] DATA_BAD  = 128'h0BAD_0BAD;
    localparam logic [127:0] DATA_DEAD = 128'hDEAD;
    localparam logic [127:0] DATA_111  = 128'h1111_0001;
    localparam logic [127:0] DATA_222  = 128'h2222_0002;
    localparam logic [127:0] DATA_C0DE = 128'hC0DE_C0DE;
    localparam logic [127:0] DATA_FEED = 128'hFEED_FACE;

    fw_result_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rt_addr (issue_rt_addr),
        .issue_idx     (issue_idx),
        .issue_wr_en   (issue_wr_en),
        .unit_res      (unit_res),
        .flush         (flush),
        .rf_addr_s2    (rf_addr_s2),
        .rf_addr_s3    (rf_addr_s3),
        .rf_addr_s4    (rf_addr_s4),
        .rf_addr_s5    (rf_addr_s5),
        .rf_addr_s6    (rf_addr_s6),
        .rf_addr_s7    (rf_addr_s7),
        .rf_data_s2    (rf_data_s2),
        .rf_data_s3    (rf_data_s3),
        .rf_data_s4    (rf_data_s4),
        .rf_data_s5    (rf_data_s5),
        .rf_data_s6    (rf_data_s6),
        .rf_data_s7    (rf_data_s7),
        .rf_idx_s2     (rf_idx_s2),
        .rf_idx_s3     (rf_idx_s3),
        .rf_idx_s4     (rf_idx_s4),
        .rf_idx_s5     (rf_idx_s5),
        .rf_idx_s6     (rf_idx_s6),
        .rf_idx_s7     (rf_idx_s7),
        .rf_addr       (rf_addr),
        .rf_data       (rf_data),
        .rf_we         (rf_we),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, then returns 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [6:0] rt, input logic [2:0] idx,
                                 input logic we, input logic fl);
        issue_valid   = v;
        issue_rt_addr = rt;
        issue_idx     = idx;
        issue_wr_en   = we;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic setRes(input int k, input logic [127:0] val);
        unit_res[k*128 +: 128] = val;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ctl"},
                    {59'd0, rf_we, busy, rf_addr,
                     rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7,
                     rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7},
                    128'd0);
        checkOutput({tag, "_data"},
                    rf_data_s2 | rf_data_s3 | rf_data_s4 | rf_data_s5 | rf_data_s6 |
                    rf_data_s7 | rf_data, 128'd0);
    endtask

    initial begin
        rst      = 1'b0;
        unit_res = '0;
        idle();
        idle();
        rst = 1'b1;
        checkIdle("reset");

        // idx1 result captured into s2, written back from s8
        applyStimulus(1'b1, 7'd5, 3'd1, 1'b1, 1'b0);
        setRes(1, DATA_A5);
        idle();
        checkOutput("t1_idx_s2", 128'(rf_idx_s2), 128'd1);
        checkOutput("t1_addr_s2", 128'(rf_addr_s2), 128'd5);
        checkOutput("t1_data_s2", rf_data_s2, DATA_A5);
        checkOutput("t1_busy", 128'(busy), 128'd1);
        unit_res = '0;
        repeat (5) idle();
        checkOutput("t1_data_s7", rf_data_s7, DATA_A5);
        checkOutput("t1_we_early", 128'(rf_we), 128'd0);
        idle();
        checkOutput("t1_wb", {119'd0, rf_we, rf_addr}, {119'd0, 1'b1, 7'd5});
        checkOutput("t1_wb_data", rf_data, DATA_A5);
        idle();
        checkOutput("t1_drain", {126'd0, rf_we, busy}, 128'd0);

        // idx3 completes in s6; a decoy on the bus earlier must not be captured
        applyStimulus(1'b1, 7'd9, 3'd3, 1'b1, 1'b0);
        setRes(3, DATA_BAD);
        idle();
        checkOutput("t2_data_s2", rf_data_s2, 128'd0);
        checkOutput("t2_idx_s2", 128'(rf_idx_s2), 128'd3);
        repeat (3) idle();
        checkOutput("t2_data_s5", rf_data_s5, 128'd0);
        setRes(3, DATA_DEAD);
        idle();
        checkOutput("t2_data_s6", rf_data_s6, DATA_DEAD);
        unit_res = '0;
        idle();
        checkOutput("t2_data_s7", rf_data_s7, DATA_DEAD);
        idle();
        checkOutput("t2_wb", {119'd0, rf_we, rf_addr}, {119'd0, 1'b1, 7'd9});
        checkOutput("t2_wb_data", rf_data, DATA_DEAD);
        idle();

        // back-to-back writes to rt=3, younger lands second
        applyStimulus(1'b1, 7'd3, 3'd1, 1'b1, 1'b0);
        setRes(1, DATA_111);
        applyStimulus(1'b1, 7'd3, 3'd2, 1'b1, 1'b0);
        unit_res = '0;
        idle();
        setRes(2, DATA_222);
        idle();
        checkOutput("t3_data_s3", rf_data_s3, DATA_222);
        checkOutput("t3_data_s4", rf_data_s4, DATA_111);
        unit_res = '0;
        repeat (4) idle();
        checkOutput("t3_wb1", {119'd0, rf_we, rf_addr}, {119'd0, 1'b1, 7'd3});
        checkOutput("t3_wb1_data", rf_data, DATA_111);
        idle();
        checkOutput("t3_wb2", {119'd0, rf_we, rf_addr}, {119'd0, 1'b1, 7'd3});
        checkOutput("t3_wb2_data", rf_data, DATA_222);
        idle();

        // flush kills s1..s3, the older entry in s5 survives, same-cycle issue dropped
        applyStimulus(1'b1, 7'd30, 3'd1, 1'b1, 1'b0);
        setRes(1, DATA_C0DE);
        idle();
        unit_res = '0;
        applyStimulus(1'b1, 7'd31, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd32, 3'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd33, 3'd4, 1'b1, 1'b0);
        checkOutput("t4_pre_idx", {122'd0, rf_idx_s2, rf_idx_s3}, {122'd0, 3'd2, 3'd2});
        applyStimulus(1'b1, 7'd34, 3'd1, 1'b1, 1'b1);
        checkOutput("t4_killed_idx", {119'd0, rf_idx_s2, rf_idx_s3, rf_idx_s4}, 128'd0);
        checkOutput("t4_killed_addr", {114'd0, rf_addr_s2, rf_addr_s3}, 128'd0);
        checkOutput("t4_survivor", {118'd0, rf_idx_s6, rf_addr_s6}, {118'd0, 3'd1, 7'd30});
        idle();
        idle();
        checkOutput("t4_wb", {119'd0, rf_we, rf_addr}, {119'd0, 1'b1, 7'd30});
        checkOutput("t4_wb_data", rf_data, DATA_C0DE);
        idle();
        checkOutput("t4_drain", {126'd0, rf_we, busy}, 128'd0);

        // non-writing, branch-unit and idx0 issues are all bubbles
        applyStimulus(1'b1, 7'd40, 3'd1, 1'b0, 1'b0);
        checkOutput("t5_nowr_busy", 128'(busy), 128'd0);
        applyStimulus(1'b1, 7'd41, 3'd7, 1'b1, 1'b0);
        checkOutput("t5_br_busy", 128'(busy), 128'd0);
        applyStimulus(1'b1, 7'd42, 3'd0, 1'b1, 1'b0);
        checkOutput("t5_idx0_busy", 128'(busy), 128'd0);
        for (int i = 0; i < 8; i++) begin
            idle();
            checkOutput("t5_we_busy", {126'd0, rf_we, busy}, 128'd0);
        end
        checkIdle("t5_taps");

        // reset with four entries in flight, issue during reset ignored
        setRes(1, DATA_FEED);
        applyStimulus(1'b1, 7'd50, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd51, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd52, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd53, 3'd1, 1'b1, 1'b0);
        checkOutput("t6_inflight", {119'd0, busy, rf_addr_s3}, {119'd0, 1'b1, 7'd51});
        rst = 1'b0;
        applyStimulus(1'b1, 7'd55, 3'd1, 1'b1, 1'b1);
        rst = 1'b1;
        checkIdle("t6_reset");
        unit_res = '0;
        for (int i = 0; i < 10; i++) begin
            idle();
            checkOutput("t6_no_write", {126'd0, rf_we, busy}, 128'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fw_result_pipe.md
Name: fw_result_pipe

Overview:
- Producer side of the operand-forwarding network: one instance per pipe (even, odd).
- Carries each issued instruction's destination tag through result stages s1..s7 and captures the executing unit's 128-bit result at that unit's completion stage.
- Drives the rf_addr_sN/rf_data_sN/rf_idx_sN taps that the forwarding mux consumes, plus the final register-file write port (s8).

Parameters:
- REG_DATA_WD, 128, result width in bits
- ADDR_WD, 7, register address width
- NUM_UNITS, 8, unit-index slots; slot 0 means "no unit/bubble"
- FLUSH_STAGES, 3, stages s1..FLUSH_STAGES cleared on flush

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- issue_valid  in  1  instruction issued this cycle
- issue_rt_addr  in  ADDR_WD  destination register
- issue_idx  in  3  executing unit index (1..7)
- issue_wr_en  in  1  instruction writes the register file
- unit_res  in  NUM_UNITS*REG_DATA_WD  unit result buses, slot k = unit k; slot 0 ignored
- flush  in  1  kill younger entries (branch mispredict)
- rf_addr_s2..rf_addr_s7  out  ADDR_WD each  stage tag taps
- rf_data_s2..rf_data_s7  out  REG_DATA_WD each  stage data taps
- rf_idx_s2..rf_idx_s7  out  3 each  stage unit-index taps
- rf_addr  out  ADDR_WD  writeback address (s8)
- rf_data  out  REG_DATA_WD  writeback data (s8)
- rf_we  out  1  writeback enable
- busy  out  1  any valid entry in s1..s8

Behaviour:
- Reset (rst==0 at a clk edge): all stage registers s1..s8 clear to addr=0, idx=0, data=0, valid=0. All taps, rf_we and busy read 0 in the cycle after reset.
- Latency table in the package (completion stage L): idx1=2; idx2=3; idx4=3; idx5=4; idx3=6; idx6=6; idx7=none (no result).
- Issue:
  - An issue_valid edge loads s1 with {rt_addr, idx, valid=1, data=0}.
  - issue_valid=0, issue_wr_en=0, or issue_idx==0/7 loads a bubble (addr=0, idx=0, valid=0).
- Advance: every cycle sN+1 <= sN, unconditionally; there is no stall.
- Capture:
  - On the edge moving an entry from s(L-1) into sL, the data field loads unit_res slot[idx]. Unit k must therefore present its result while the entry sits in s(L-1).
  - Stages before L carry data=0. Stages after L carry the captured data unchanged.
- Taps: sN outputs are direct register outputs, with 0 latency from the stage register.
- Writeback:
  - s8 drives rf_addr/rf_data.
  - rf_we = s8.valid.
  - One write per cycle; a write always completes 8 cycles after the issue edge.
- Flush:
  - On a flush edge, entries advancing into s2..FLUSH_STAGES+1 become bubbles, and s1 loads a bubble regardless of issue_valid. Net effect: the contents of s1..FLUSH_STAGES are killed.
  - Older entries advance and write back normally.
- Simultaneous events:
  - flush beats issue.
  - Reset beats flush and issue.
  - Reset mid-operation discards all in-flight entries; no partial write.
- Back-to-back issues to the same rt are both kept; the younger overwrites the register later (in order).
- busy = OR of valid bits s1..s8.

Decomposition:
- Shared package fw_pkg:
  - unit index constants (UNIT_NONE=0 .. UNIT_BR=7)
  - function unit_lat(idx) returning the completion stage
  - localparam NUM_RES_STAGES=8
  - packed struct res_entry_t {valid, addr, idx, data}
- Sub-module fw_res_stage: one stage register with capture mux (capture-enable when unit_lat(in.idx)==STAGE), flush and reset. Instantiated 8 times via generate.

Test Plan:
- Single idx1 issue, rt=5, unit_res[1]=128'hA5.. presented on cycle 1 -> rf_idx_s2=1, rf_data_s2=A5.. at cycle 2; rf_we=1, rf_addr=5 at cycle 8.
- idx3 issue rt=9, unit_res[3]=0xDEAD presented only on cycle 5 -> rf_data_s2..s5=0, rf_data_s6=s7=0xDEAD, written back at cycle 8.
- Issues with idx1 (rt=3) then idx2 (rt=3) on consecutive cycles -> two writes on cycles 8 and 9, second data wins.
- Three issues, then flush one cycle after the third -> s1..s3 entries killed (rf_idx taps 0), older entries still write back; issue on the flush cycle dropped.
- issue_wr_en=0 or idx7 -> bubble in every tap, rf_we never asserted, busy stays 0.
- Reset (rst=0) while four entries are in flight -> every tap and rf_we = 0 the next cycle, busy=0, no write occurs.
